// File: rtl/cla_pipe_adder_16b_pkg.sv
// Shared constants and result-flag type for the pipelined CLA adder and the ALU result mux.
package cla_pipe_adder_16b_pkg;

    localparam int unsigned ADD_WIDTH = 16;
    localparam int unsigned CLA_GROUP = 4;

    typedef struct packed {
        logic c_out;
        logic ofl;
        logic zero;
    } res_flags_t;

endpackage

// File: rtl/cla_group_4b.sv
// 4-bit carry-lookahead group: internal carries plus group generate/propagate.
module cla_group_4b (
    input  logic [3:0] i_g,
    input  logic [3:0] i_p,
    input  logic       i_c,
    output logic [3:1] o_c,
    output logic       o_gg,
    output logic       o_gp
);

    assign o_c[1] = i_g[0] | (i_p[0] & i_c);
    assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
    assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_c);

    assign o_gg = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);
    assign o_gp = &i_p;

endmodule

// File: rtl/cla_pipe_adder_16b.sv
// Two-stage pipelined CLA adder/subtractor: lower half in stage 1, upper half and flags in
// stage 2, with a valid/ready handshake on both sides.
module cla_pipe_adder_16b
    import cla_pipe_adder_16b_pkg::*;
#(
    parameter int unsigned WIDTH = ADD_WIDTH,
    parameter int unsigned GROUP = CLA_GROUP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c_out,
    output logic             o_ofl,
    output logic             o_zero
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned NG   = HALF / GROUP;

    logic             w_s2_free, w_s1_adv, w_accept;
    logic [WIDTH-1:0] w_b_eff, w_g, w_p;

    logic [NG-1:0]    w_gg_lo, w_gp_lo, w_gg_hi, w_gp_hi;
    logic [NG:0]      w_gc_lo, w_gc_hi;
    logic [3:1]       w_ic_lo [NG];
    logic [3:1]       w_ic_hi [NG];
    logic [HALF-1:0]  w_c_lo, w_c_hi, w_sum_lo, w_sum_hi;
    logic [WIDTH-1:0] w_sum;
    res_flags_t       w_flags;

    logic             r_s1_valid;
    logic [HALF-1:0]  r_s1_sum_lo, r_s1_g_hi, r_s1_p_hi;
    logic             r_s1_c_mid;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    res_flags_t       r_flags;

    assign w_s2_free  = !r_out_valid || i_out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    assign o_in_ready = !r_s1_valid || w_s2_free;
    assign w_accept   = i_in_valid && o_in_ready;

    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign w_g     = i_a & w_b_eff;
    assign w_p     = i_a ^ w_b_eff;

    // Second-level lookahead over group G/P, one chain per half.
    always_comb begin
        logic c;
        w_gc_lo    = '0;
        c          = i_sub;
        w_gc_lo[0] = c;
        for (int k = 0; k < NG; k++) begin
            c            = w_gg_lo[k] | (w_gp_lo[k] & c);
            w_gc_lo[k+1] = c;
        end
    end

    always_comb begin
        logic c;
        w_gc_hi    = '0;
        c          = r_s1_c_mid;
        w_gc_hi[0] = c;
        for (int k = 0; k < NG; k++) begin
            c            = w_gg_hi[k] | (w_gp_hi[k] & c);
            w_gc_hi[k+1] = c;
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_groups
        cla_group_4b u_grp_lo (
            .i_g  (w_g[k*GROUP +: GROUP]),
            .i_p  (w_p[k*GROUP +: GROUP]),
            .i_c  (w_gc_lo[k]),
            .o_c  (w_ic_lo[k]),
            .o_gg (w_gg_lo[k]),
            .o_gp (w_gp_lo[k])
        );
        cla_group_4b u_grp_hi (
            .i_g  (r_s1_g_hi[k*GROUP +: GROUP]),
            .i_p  (r_s1_p_hi[k*GROUP +: GROUP]),
            .i_c  (w_gc_hi[k]),
            .o_c  (w_ic_hi[k]),
            .o_gg (w_gg_hi[k]),
            .o_gp (w_gp_hi[k])
        );
        assign w_c_lo[k*GROUP]          = w_gc_lo[k];
        assign w_c_lo[k*GROUP+1 +: 3]   = w_ic_lo[k];
        assign w_c_hi[k*GROUP]          = w_gc_hi[k];
        assign w_c_hi[k*GROUP+1 +: 3]   = w_ic_hi[k];
    end

    assign w_sum_lo = w_p[HALF-1:0] ^ w_c_lo;
    assign w_sum_hi = r_s1_p_hi ^ w_c_hi;
    assign w_sum    = {w_sum_hi, r_s1_sum_lo};

    // Overflow: carry into the MSB differs from carry out of it.
    assign w_flags.c_out = w_gc_hi[NG];
    assign w_flags.ofl   = w_c_hi[HALF-1] ^ w_gc_hi[NG];
    assign w_flags.zero  = (w_sum == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sum_lo <= '0;
            r_s1_c_mid  <= 1'b0;
            r_s1_g_hi   <= '0;
            r_s1_p_hi   <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid  <= 1'b1;
                r_s1_sum_lo <= w_sum_lo;
                r_s1_c_mid  <= w_gc_lo[NG];
                r_s1_g_hi   <= w_g[WIDTH-1:HALF];
                r_s1_p_hi   <= w_p[WIDTH-1:HALF];
            end else if (w_s1_adv) begin
                r_s1_valid  <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_flags     <= '0;
        end else begin
            if (w_s2_free) begin
                r_out_valid <= r_s1_valid;
            end
            if (w_s1_adv) begin
                r_sum   <= w_sum;
                r_flags <= w_flags;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_sum       = r_sum;
    assign o_c_out     = r_flags.c_out;
    assign o_ofl       = r_flags.ofl;
    assign o_zero      = r_flags.zero;

endmodule

// File: tb/tb_cla_pipe_adder_16b.sv
// Self-checking bench for cla_pipe_adder_16b: directed vectors, stall/reset sequences and
// randomized traffic against an arithmetic reference model with an in-order scoreboard.
module tb_cla_pipe_adder_16b;

    typedef struct packed {
        logic [15:0] sum;
        logic        c_out;
        logic        ofl;
        logic        zero;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        res_t        exp;
    } vec_t;

    logic        clk, rst_n, in_valid, in_ready, sub, out_valid, out_ready;
    logic        c_out, ofl, zero;
    logic [15:0] a, b, sum;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    int   n_out = 0;
    res_t exp_q[$];
    int   arrivals[$];
    logic stalled = 1'b0;
    res_t held;
    vec_t vecs[8];

    cla_pipe_adder_16b dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_a         (a),
        .i_b         (b),
        .i_sub       (sub),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_sum       (sum),
        .o_c_out     (c_out),
        .o_ofl       (ofl),
        .o_zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands.
    function automatic res_t model(logic [15:0] xa, logic [15:0] xb, logic xsub);
        res_t r;
        int   ua, ub, sa, sb, sr;
        ua = int'(xa);
        ub = int'(xb);
        sa = int'($signed(xa));
        sb = int'($signed(xb));
        if (xsub) begin
            r.sum   = xa - xb;
            r.c_out = (ua >= ub);
            sr      = sa - sb;
        end else begin
            r.sum   = xa + xb;
            r.c_out = (ua + ub) > 65535;
            sr      = sa + sb;
        end
        r.ofl  = (sr > 32767) || (sr < -32768);
        r.zero = (r.sum == 16'h0000);
        return r;
    endfunction

    function automatic vec_t mk(logic [15:0] xa, logic [15:0] xb, logic xsub,
                                logic [15:0] s, logic c, logic o, logic z);
        vec_t v;
        v.a   = xa;
        v.b   = xb;
        v.sub = xsub;
        v.exp = {s, c, o, z};
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic res_t outs();
        return {sum, c_out, ofl, zero};
    endfunction

    // One clock: called at a negedge with this cycle's inputs already driven.
    task automatic cycle();
        res_t act;
        res_t exp;
        logic s1_busy;
        #1;
        act = outs();
        if (stalled) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(act), 32'(held));
        end
        s1_busy = exp_q.size() > (out_valid ? 1 : 0);
        check("in_ready", 32'(in_ready), 32'(!s1_busy || !out_valid || out_ready));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                exp = exp_q.pop_front();
                check("result", 32'(act), 32'(exp));
                arrivals.push_back(cyc);
                n_out++;
            end
        end
        stalled = out_valid && !out_ready;
        held    = act;
        if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, sub));
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_op();
        a   = 16'($urandom);
        b   = 16'($urandom);
        sub = 1'($urandom);
    endtask

    initial begin
        int start, acc0, out0, guard;

        vecs[0] = mk(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        vecs[1] = mk(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        vecs[2] = mk(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        vecs[3] = mk(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        vecs[4] = mk(16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        vecs[5] = mk(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        vecs[6] = mk(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        vecs[7] = mk(16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", 32'(outs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        // Fill both stages under back-pressure, then reset for one cycle.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            rand_op();
            cycle();
        end
        check("full_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs", 32'(outs()), 32'd0);
        exp_q.delete();
        stalled = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("no_stale", 32'(out_valid), 32'd0);
            cycle();
        end

        // Directed vectors, one at a time, with latency checks.
        foreach (vecs[i]) begin
            a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub;
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            #1 check("lat_early", 32'(out_valid), 32'd0);
            cycle();
            #1;
            check("lat_valid", 32'(out_valid), 32'd1);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            cycle();
        end

        // Streaming: 8 back-to-back ops.
        arrivals.delete();
        start = cyc;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            rand_op();
            #1 check("stream_in_ready", 32'(in_ready), 32'd1);
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("stream_count", 32'(arrivals.size()), 32'd8);
        foreach (arrivals[i]) check("stream_cycle", 32'(arrivals[i]), 32'(start + 2 + i));

        // Back-pressure from an empty pipe: exactly two ops fit.
        acc0 = n_acc;
        out0 = n_out;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            rand_op();
            cycle();
        end
        check("bp_accepted", 32'(n_acc - acc0), 32'd2);
        #1 check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_op();
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("bp_no_loss", 32'(n_out - out0), 32'(n_acc - acc0));

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_op();
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            cycle();
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder_16b.md
Name: cla_pipe_adder_16b

Overview:
- Two-stage pipelined carry-lookahead adder/subtractor.
- Consumes per-bit generate/propagate terms (g = a&b, p = a^b) and combines them through 4-bit lookahead groups.
- Produces a registered sum plus carry, signed-overflow and zero flags.
- Sits between the operand-select logic and the ALU result mux; uses a valid/ready handshake so a stalled consumer back-pressures cleanly.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 2*GROUP.
- GROUP, 4, bits per lookahead group.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on a/b/sub are valid.
- in_ready  output  1  the block accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1: A-B (B inverted, carry-in 1); 0: A+B (carry-in 0).
- out_valid  output  1  result outputs are valid.
- out_ready  input  1  consumer takes the result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB; for subtract, 1 means no borrow.
- ofl  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset: asynchronous on rst_n low.
  - All valid flags clear; all data registers clear.
  - out_valid=0, sum=0, c_out=0, ofl=0, zero=0.
  - in_ready=1 once rst_n is high.
- Operand transfer: occurs when in_valid && in_ready at a clock edge. Result transfer: occurs when out_valid && out_ready.
- Stage 1 (combinational from inputs, registered at the transfer edge):
  - b_eff = sub ? ~b : b; cin = sub.
  - Per-bit g/p over all WIDTH bits.
  - Lower WIDTH/2 bits: sum and group carries computed through lookahead groups.
  - Registers: lower sum, carry into bit WIDTH/2, upper-half g/p, upper operand MSBs.
- Stage 2: from the registered carry and upper g/p, compute the upper sum, c_out, ofl and zero. These are registered into the output registers.
- Latency: exactly 2 cycles from the transfer edge to out_valid, with no stall.
- Throughput: one operation per cycle.
- Stall rules:
  - s2_free = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free.
  - in_ready must not depend on in_valid.
- Holding: while out_valid && !out_ready, sum/c_out/ofl/zero and out_valid hold unchanged. Stage 1 holds if occupied.
- Simultaneous events: when both stages are full and out_ready=1, one result leaves, stage 1 moves to stage 2 and a new operand is accepted, all in the same cycle. No bubble is inserted.
- Empty pipe: out_valid stays 0. Output data registers keep their last value, which is don't-care for the checker.
- Arithmetic: WIDTH-bit two's complement; wrap-around at 2^WIDTH. No saturation.
- Reset mid-operation: all in-flight operations are discarded and no partial result is ever presented. The first operation after reset is accepted on the first edge with rst_n high and in_valid=1.
- X handling: a/b/sub are ignored when in_valid=0.

Decomposition:
- Shared package holds:
  - ADD_WIDTH=16 and CLA_GROUP=4 constants.
  - A result-flags typedef (c_out, ofl, zero) reused by the ALU result mux.
- One sub-module, cla_group_4b:
  - Inputs: 4 bits of g/p and a carry-in.
  - Outputs: 3 internal carries, group G and group P.
  - Instantiated WIDTH/GROUP times, split across the two stages.
  - Second-level lookahead over group G/P is done inline per half.

Test Plan:
1. Reset while both stages are full (back-to-back ops, out_ready=0), rst_n low for 1 cycle -> out_valid=0 immediately. All flags 0 after release. No stale result appears.
2. Single add: a=16'h1234, b=16'h4321, sub=0 -> 2 cycles later out_valid=1, sum=16'h5555, c_out=0, ofl=0, zero=0.
3. Carry/overflow edges:
   - 16'hFFFF+16'h0001 -> sum=0, c_out=1, ofl=0, zero=1.
   - 16'h7FFF+16'h0001 -> sum=16'h8000, ofl=1, c_out=0.
   - Subtract 16'h8000-16'h0001 -> sum=16'h7FFF, ofl=1, c_out=1.
4. Streaming: 8 ops back-to-back with out_ready=1 -> in_ready stays 1, results arrive in order on 8 consecutive cycles starting at cycle 2.
5. Back-pressure: out_ready=0 for 5 cycles mid-stream -> in_ready drops after 2 accepted ops, the output holds stable. On release, no op is lost or duplicated, ordering is preserved, and the comparison against a reference model passes.
6. Random: 10k random a/b/sub with random in_valid/out_ready -> every result matches the {c_out,sum} = a ± b model, with flags checked.
